// File: rtl/i2s_in_sched.sv
// Round-robin packetiser: merges CN per-channel byte streams into one output
// stream. Each packet is [channel index][destination index][payload...],
// with payloads cut at MAX_BYTES and the remaining source bytes discarded.
module i2s_in_sched #(
  parameter int CN        = 16,
  parameter int MAX_BYTES = 256
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [8*CN-1:0]     s_axis_tdata,
  input  logic [CN-1:0]       s_axis_tvalid,
  input  logic [CN-1:0]       s_axis_tlast,
  output logic [CN-1:0]       s_axis_tready,
  output logic [7:0]          m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  input  logic [CN-1:0]       i_enable,
  input  logic [4*CN-1:0]     i_dst_fpga_index,
  output logic                o_busy,
  output logic [7:0]          o_cur_channel,
  output logic [15:0]         o_pkt_count,
  output logic [15:0]         o_trunc_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  localparam logic [15:0] LP_LAST_IDX = 16'(MAX_BYTES - 1);
  localparam logic [7:0]  LP_LAST_CH  = 8'(CN - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_grant;
  logic [7:0]  r_last_grant;
  logic [15:0] r_byte_cnt;
  logic [15:0] r_pkt_count;
  logic [15:0] r_trunc_count;

  logic [CN-1:0] w_req;
  logic          w_any;
  logic [8:0]    w_rr_start;
  logic          w_found_hi;
  logic [7:0]    w_pick_hi;
  logic [7:0]    w_pick_lo;
  logic [7:0]    w_pick;

  logic [CN-1:0] w_gmask;
  logic [7:0]    w_sel_data;
  logic          w_sel_valid;
  logic          w_sel_last;
  logic [3:0]    w_sel_dst;
  logic          w_at_max;
  logic          w_pay_xfer;

  assign w_req      = s_axis_tvalid & i_enable;
  assign w_any      = |w_req;
  assign w_rr_start = (r_last_grant == LP_LAST_CH) ? 9'd0 : ({1'b0, r_last_grant} + 9'd1);
  assign w_at_max   = (r_byte_cnt == LP_LAST_IDX);
  assign w_pay_xfer = (r_state == ST_PAYLOAD) && w_sel_valid && m_axis_tready;

  // Round-robin pick: lowest requester at/above the start point, else lowest overall
  always_comb begin
    w_found_hi = 1'b0;
    w_pick_hi  = 8'd0;
    w_pick_lo  = 8'd0;
    for (int i = CN - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_pick_lo = 8'(i);
        if (i >= int'(w_rr_start)) begin
          w_pick_hi  = 8'(i);
          w_found_hi = 1'b1;
        end
      end
    end
    w_pick = w_found_hi ? w_pick_hi : w_pick_lo;
  end

  // Select the granted channel's stream signals and destination
  always_comb begin
    w_gmask     = '0;
    w_sel_data  = 8'd0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_dst   = 4'd0;
    for (int i = 0; i < CN; i++) begin
      if (r_grant == 8'(i)) begin
        w_gmask[i]  = 1'b1;
        w_sel_data  = s_axis_tdata[8*i +: 8];
        w_sel_valid = s_axis_tvalid[i];
        w_sel_last  = s_axis_tlast[i];
        w_sel_dst   = i_dst_fpga_index[4*i +: 4];
      end
    end
  end

  // Next-state and output decode; disabled, non-granted channels always flush
  always_comb begin
    w_state_nxt   = r_state;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'd0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = ~i_enable;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_nxt = ST_HDR0;
      end
      ST_HDR0: begin
        s_axis_tready = ~i_enable & ~w_gmask;
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = r_grant;
        if (m_axis_tready) w_state_nxt = ST_HDR1;
      end
      ST_HDR1: begin
        s_axis_tready = ~i_enable & ~w_gmask;
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {4'b0000, w_sel_dst};
        if (m_axis_tready) w_state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        s_axis_tready = (~i_enable & ~w_gmask) | (w_gmask & {CN{m_axis_tready}});
        m_axis_tvalid = w_sel_valid;
        m_axis_tdata  = w_sel_data;
        m_axis_tlast  = w_sel_last | w_at_max;
        if (w_pay_xfer) begin
          if (w_sel_last)    w_state_nxt = ST_IDLE;
          else if (w_at_max) w_state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        s_axis_tready = (~i_enable & ~w_gmask) | w_gmask;
        if (w_sel_valid && w_sel_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Grant capture, payload byte count and packet/truncation counters
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_grant       <= 8'd0;
      r_last_grant  <= LP_LAST_CH;
      r_byte_cnt    <= 16'd0;
      r_pkt_count   <= 16'd0;
      r_trunc_count <= 16'd0;
    end else begin
      if (r_state == ST_IDLE && w_any) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
        r_byte_cnt   <= 16'd0;
      end
      if (w_pay_xfer) begin
        r_byte_cnt <= r_byte_cnt + 16'd1;
        if (w_sel_last || w_at_max) r_pkt_count <= r_pkt_count + 16'd1;
        if (!w_sel_last && w_at_max && r_trunc_count != 16'hFFFF)
          r_trunc_count <= r_trunc_count + 16'd1;
      end
    end
  end

  assign o_busy        = (r_state != ST_IDLE);
  assign o_cur_channel = r_grant;
  assign o_pkt_count   = r_pkt_count;
  assign o_trunc_count = r_trunc_count;

endmodule
